// File: rtl/seg_scan_scheduler.sv
// seg_scan_scheduler
//   Time-multiplexed scan controller for a 4-digit common 7-segment display.
//   Frames of four 8-bit segment patterns arrive over a valid/ready handshake
//   into a shadow buffer. The shadow buffer is copied to the active buffer only
//   at a frame boundary, so a displayed frame never tears. Each digit slot opens
//   with dead-time blanking, then stays lit for brightness*STEP cycles, then
//   stays dark for the rest of the slot.
//
// Ports
//   clkIn          in   system clock
//   resetIn        in   asynchronous active-low reset
//   enable         in   1 = scanning, 0 = dark and parked at digit 0
//   brightness     in   [3:0] 0 = dark .. 15 = max, latched as each slot starts
//   frameData      in   [31:0] digit d pattern in bits [8d+7:8d]
//   frameValid     in   frameData valid
//   frameReady     out  shadow buffer free
//   digitEnable    out  [3:0] one-hot digit select, active-high
//   segmentEnable  out  [7:0] segment pattern of the selected digit
//   frameStart     out  one-cycle pulse in the digit-0 slot-start cycle
module seg_scan_scheduler #(
  parameter int CLK_FREQUENCY = 27000000,
  parameter int SCAN_HZ       = 1000,
  parameter int BLANK_CYCLES  = 27
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        enable,
  input  logic [3:0]  brightness,
  input  logic [31:0] frameData,
  input  logic        frameValid,
  output logic        frameReady,
  output logic [3:0]  digitEnable,
  output logic [7:0]  segmentEnable,
  output logic        frameStart
);

  localparam int SLOT_CYCLES = CLK_FREQUENCY / SCAN_HZ;
  localparam int STEP        = (SLOT_CYCLES - BLANK_CYCLES) / 15;
  localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  if (STEP < 1) begin : g_step_check
    $error("seg_scan_scheduler: slot too short for 15 brightness steps after blanking");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    LIT   = 2'd2,
    DARK  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         bright_q, bright_d;
  logic [31:0]        active_q, active_d;
  logic [31:0]        shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic [3:0]         dig_q, dig_d;
  logic [7:0]         seg_q, seg_d;
  logic               fs_q, fs_d;
  logic [31:0]        lit_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    bright_d  = bright_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    lit_end   = '0;
    dig_d     = '0;
    seg_d     = '0;

    // fs_q marks the current cycle as the frame boundary. A swap needs
    // pending_q=1 and an accept needs pending_q=0, so the two are exclusive.
    if (fs_q && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (frameValid && !pending_q) begin
      shadow_d  = frameData;
      pending_d = 1'b1;
    end

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      if (state_q == IDLE) begin
        cnt_d    = '0;
        idx_d    = '0;
        bright_d = brightness;
      end else if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
        cnt_d    = '0;
        idx_d    = idx_q + 2'd1;
        bright_d = brightness;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // The phase within the slot follows directly from the slot counter.
      lit_end = 32'(BLANK_CYCLES) + 32'(bright_d) * 32'(STEP);
      if (32'(cnt_d) < 32'(BLANK_CYCLES)) begin
        state_d = BLANK;
      end else if (32'(cnt_d) < lit_end) begin
        state_d = LIT;
      end else begin
        state_d = DARK;
      end
    end

    // Outputs are computed from next-state values and registered, so they
    // line up with the slot cycle they describe, and digit and segment
    // enables change on the same edge.
    fs_d = (state_d != IDLE) && (cnt_d == '0) && (idx_d == 2'd0);
    if (state_d == LIT) begin
      dig_d = 4'b0001 << idx_d;
      seg_d = active_d[{idx_d, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      bright_q  <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      dig_q     <= '0;
      seg_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bright_q  <= bright_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      dig_q     <= dig_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  assign frameReady    = ~pending_q;
  assign digitEnable   = dig_q;
  assign segmentEnable = seg_q;
  assign frameStart    = fs_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
`timescale 1ns/1ps
// Testbench for seg_scan_scheduler. A reference model tracks absolute time
// since scanning started and derives slot, digit and lit window from it with
// plain arithmetic; the frame handshake is modelled as a one-entry buffer.
module tb_seg_scan_scheduler;
  localparam int CLK_FREQUENCY = 1600;
  localparam int SCAN_HZ       = 50;
  localparam int BLANK_CYCLES  = 2;
  localparam int SLOT          = CLK_FREQUENCY / SCAN_HZ;      // 32
  localparam int STEPC         = (SLOT - BLANK_CYCLES) / 15;   // 2
  localparam int FRAME         = 4 * SLOT;                     // 128

  logic        clkIn = 1'b0;
  logic        resetIn = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  brightness = 4'd0;
  logic [31:0] frameData = 32'd0;
  logic        frameValid = 1'b0;
  logic        frameReady;
  logic [3:0]  digitEnable;
  logic [7:0]  segmentEnable;
  logic        frameStart;
  logic [13:0] obs;

  assign obs = {digitEnable, segmentEnable, frameStart, frameReady};

  always #5 clkIn = ~clkIn;

  seg_scan_scheduler #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .SCAN_HZ(SCAN_HZ),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clkIn(clkIn),
    .resetIn(resetIn),
    .enable(enable),
    .brightness(brightness),
    .frameData(frameData),
    .frameValid(frameValid),
    .frameReady(frameReady),
    .digitEnable(digitEnable),
    .segmentEnable(segmentEnable),
    .frameStart(frameStart)
  );

  int tests = 0;
  int fails = 0;

  // reference model state
  int          m_t;         // cycles since scanning started, -1 when idle
  int          m_b;         // brightness of the current slot
  bit          m_pending;
  bit          m_fs;        // current cycle is a frame boundary
  bit          m_accepted;  // the last edge transferred a frame
  logic [31:0] m_active;
  logic [31:0] m_shadow;
  int          m_accept_count = 0;

  task automatic model_reset();
    m_t = -1; m_b = 0; m_pending = 0; m_fs = 0; m_accepted = 0;
    m_active = '0; m_shadow = '0;
  endtask

  // Advance the model across one rising edge using the inputs present at it.
  task automatic model_edge();
    m_accepted = 0;
    if (m_fs && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end else if (frameValid && !m_pending) begin
      m_shadow   = frameData;
      m_pending  = 1;
      m_accepted = 1;
      m_accept_count++;
      $display("[TB] %0t accept frame %h", $time, frameData);
    end
    if (!enable) m_t = -1;
    else begin
      m_t++;
      if (m_t % SLOT == 0) m_b = int'(brightness);
    end
    m_fs = (m_t >= 0) && (m_t % FRAME == 0);
  endtask

  function automatic logic [13:0] expected();
    logic [3:0] d;
    logic [7:0] s;
    int c;
    int idx;
    d = '0;
    s = '0;
    if (m_t >= 0) begin
      c   = m_t % SLOT;
      idx = (m_t / SLOT) % 4;
      if (c >= BLANK_CYCLES && c < BLANK_CYCLES + m_b * STEPC) begin
        d = 4'(1 << idx);
        s = m_active[idx*8 +: 8];
      end
    end
    return {d, s, m_fs, !m_pending};
  endfunction

  task automatic cyc();
    @(posedge clkIn);
    model_edge();
    @(negedge clkIn);
  endtask

  task automatic test_reset();
    resetIn = 1'b0; enable = 1'b0; frameValid = 1'b0;
    repeat (2) @(negedge clkIn);
    model_reset();
    tests++;
    if (obs !== 14'b0000_00000000_0_1) begin
      fails++; $display("FAIL reset_state: got %b expected %b", obs, 14'b0000_00000000_0_1);
    end
    resetIn = 1'b1;
    cyc();
    tests++;
    if (obs !== expected()) begin
      fails++; $display("FAIL idle_after_reset: got %b expected %b", obs, expected());
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_brightness();
    int lit = 0;
    frameData = 32'h3F065B4F; frameValid = 1'b1; brightness = 4'd15;
    cyc();
    frameValid = 1'b0;
    tests++;
    if (frameReady !== 1'b0) begin
      fails++; $display("FAIL ready_after_accept: got %b expected 0", frameReady);
    end
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL full_bright cyc %0d: got %b expected %b", i, obs, expected());
      end
      if (i == 0) begin
        tests++;
        if (frameStart !== 1'b1) begin
          fails++; $display("FAIL first_frame_start: got %b expected 1", frameStart);
        end
      end
      if (i == 2) begin
        tests++;
        if ({digitEnable, segmentEnable} !== {4'b0001, 8'h4F}) begin
          fails++; $display("FAIL digit0_pattern: got %b/%h expected 0001/4f", digitEnable, segmentEnable);
        end
      end
      if (i >= FRAME && digitEnable != 4'd0) lit++;
    end
    tests++;
    if (lit != 4 * (SLOT - BLANK_CYCLES)) begin
      fails++; $display("FAIL full_bright_lit_count: got %0d expected %0d", lit, 4 * (SLOT - BLANK_CYCLES));
    end
    $display("[TB] full brightness frame checked");
  endtask

  task automatic test_brightness();
    int lit = 0;
    int fsn = 0;
    brightness = 4'd4;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL bright4 cyc %0d: got %b expected %b", i, obs, expected());
      end
      if (i >= FRAME && digitEnable != 4'd0) lit++;
    end
    tests++;
    if (lit != 4 * 4 * STEPC) begin
      fails++; $display("FAIL bright4_lit_count: got %0d expected %0d", lit, 4 * 4 * STEPC);
    end
    brightness = 4'd0;
    lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL bright0 cyc %0d: got %b expected %b", i, obs, expected());
      end
      if (i >= FRAME) begin
        if (digitEnable != 4'd0 || segmentEnable != 8'd0) lit++;
        if (frameStart) fsn++;
      end
    end
    tests++;
    if (lit != 0 || fsn != 1) begin
      fails++; $display("FAIL bright0_dark: lit %0d starts %0d expected lit 0 starts 1", lit, fsn);
    end
    $display("[TB] brightness levels checked");
  endtask

  task automatic test_handshake();
    int guard = 0;
    brightness = 4'd15;
    while (m_t % FRAME != 40 && guard < 2 * FRAME) begin
      cyc(); guard++;
    end
    frameData = 32'h00000001; frameValid = 1'b1;
    cyc();
    tests++;
    if (frameReady !== 1'b0) begin
      fails++; $display("FAIL second_frame_accept: ready %b expected 0", frameReady);
    end
    frameData = 32'hA5A5A5A5;   // third frame held valid
    guard = 0;
    while (!m_fs && guard < 2 * FRAME) begin
      cyc(); guard++;
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL hs_wait cyc %0d: got %b expected %b", guard, obs, expected());
      end
    end
    tests++;
    if (frameStart !== 1'b1 || frameReady !== 1'b0) begin
      fails++; $display("FAIL hs_boundary: start %b ready %b expected 1 0", frameStart, frameReady);
    end
    cyc();
    tests++;
    if (frameReady !== 1'b1) begin
      fails++; $display("FAIL hs_ready_rise: got %b expected 1", frameReady);
    end
    cyc();
    frameValid = 1'b0;
    tests++;
    if ({frameReady, digitEnable, segmentEnable} !== {1'b0, 4'b0001, 8'h01}) begin
      fails++; $display("FAIL hs_third_and_show: got %b/%b/%h expected 0/0001/01",
                        frameReady, digitEnable, segmentEnable);
    end
    for (int i = 0; i < FRAME + 8; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL hs_after cyc %0d: got %b expected %b", i, obs, expected());
      end
    end
    $display("[TB] handshake checked");
  endtask

  task automatic test_enable_toggle();
    int guard = 0;
    while (m_t % FRAME != 2 * SLOT + 5 && guard < 2 * FRAME) begin
      cyc(); guard++;
    end
    enable = 1'b0;
    cyc();
    tests++;
    if ({digitEnable, segmentEnable, frameStart} !== 13'd0) begin
      fails++; $display("FAIL disable_dark: got %b expected 0", {digitEnable, segmentEnable, frameStart});
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL disabled cyc %0d: got %b expected %b", i, obs, expected());
      end
    end
    enable = 1'b1;
    cyc();
    tests++;
    if ({frameStart, digitEnable} !== {1'b1, 4'b0000}) begin
      fails++; $display("FAIL reenable_start: got %b/%b expected 1/0000", frameStart, digitEnable);
    end
    cyc();
    cyc();
    tests++;
    if (digitEnable !== 4'b0001) begin
      fails++; $display("FAIL reenable_digit0: got %b expected 0001", digitEnable);
    end
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL reenabled cyc %0d: got %b expected %b", i, obs, expected());
      end
    end
    $display("[TB] enable toggle checked");
  endtask

  task automatic test_brightness_mid();
    int guard = 0;
    int lit = 0;
    while (m_t % SLOT != 10 && guard < 2 * SLOT) begin
      cyc(); guard++;
    end
    brightness = 4'd2;
    for (int i = 0; i < 54; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL bright_mid cyc %0d: got %b expected %b", i, obs, expected());
      end
      if (digitEnable != 4'd0) lit++;
    end
    tests++;
    if (lit != 25) begin
      fails++; $display("FAIL bright_mid_lit_count: got %0d expected 25", lit);
    end
    $display("[TB] mid-slot brightness change checked");
  endtask

  task automatic test_async_reset();
    int guard = 0;
    int lit = 0;
    int segs = 0;
    brightness = 4'd15;
    while (m_t % FRAME != 20 && guard < 2 * FRAME) begin
      cyc(); guard++;
    end
    frameData = 32'hFFFFFFFF; frameValid = 1'b1;
    cyc();
    frameValid = 1'b0;
    #2 resetIn = 1'b0;
    #1;
    tests++;
    if (obs !== 14'b0000_00000000_0_1) begin
      fails++; $display("FAIL async_reset: got %b expected %b", obs, 14'b0000_00000000_0_1);
    end
    model_reset();
    enable = 1'b0;
    @(negedge clkIn);
    resetIn = 1'b1;
    cyc();
    enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL post_reset cyc %0d: got %b expected %b", i, obs, expected());
      end
      if (digitEnable != 4'd0) lit++;
      if (segmentEnable != 8'd0) segs++;
    end
    tests++;
    if (lit != 4 * (SLOT - BLANK_CYCLES) || segs != 0) begin
      fails++; $display("FAIL pending_discarded: lit %0d segs %0d expected %0d 0",
                        lit, segs, 4 * (SLOT - BLANK_CYCLES));
    end
    $display("[TB] asynchronous reset checked");
  endtask

  task automatic test_back_to_back();
    int start_count = m_accept_count;
    for (int i = 0; i < 3000; i++) begin
      if (!frameValid || m_accepted) begin
        frameValid = ($urandom_range(0, 2) == 0);
        frameData  = $urandom;
      end
      if ($urandom_range(0, 96) == 0) brightness = 4'($urandom);
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      cyc();
      tests++;
      if (obs !== expected()) begin
        fails++; $display("FAIL random cyc %0d: got %b expected %b", i, obs, expected());
      end
    end
    frameValid = 1'b0;
    tests++;
    if (m_accept_count - start_count < 10) begin
      fails++; $display("FAIL random_transfers: got %0d expected at least 10", m_accept_count - start_count);
    end
    $display("[TB] random traffic checked");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_brightness();
    test_brightness();
    test_handshake();
    test_enable_toggle();
    test_brightness_mid();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
